// File: rtl/bit_unswizzle_rx_pkg.sv
// rtl/bit_unswizzle_rx_pkg.sv - field positions, decoded-word type and decode function for the 9-bit swizzle word
package swz_pkg;

  // Swizzle word layout: Y = {C[2:1], {3{D[0]}}, C[0], CONST}
  localparam int C_HI_MSB  = 8;
  localparam int C_HI_LSB  = 7;
  localparam int REP_MSB   = 6;
  localparam int REP_LSB   = 4;
  localparam int C_LO      = 3;
  localparam int CONST_MSB = 2;
  localparam int CONST_LSB = 0;

  localparam logic [2:0] SWZ_CONST = 3'b101;

  typedef struct packed {
    logic [2:0] c;
    logic       d0;
    logic [1:0] err;  // [1] constant mismatch, [0] replication mismatch
  } swz_dec_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic swz_dec_t swz_decode(input logic [8:0] y,
                                          input logic [2:0] const_pat = SWZ_CONST);
    swz_dec_t   d;
    logic [2:0] rep;
    rep      = y[REP_MSB:REP_LSB];
    d.c      = {y[C_HI_MSB:C_HI_LSB], y[C_LO]};
    d.d0     = (rep[0] & rep[1]) | (rep[0] & rep[2]) | (rep[1] & rep[2]);
    d.err[1] = (y[CONST_MSB:CONST_LSB] != const_pat);
    d.err[0] = (rep != 3'b000) && (rep != 3'b111);
    return d;
  endfunction

endpackage

// File: rtl/bit_unswizzle_rx_if.sv
// rtl/bit_unswizzle_rx_if.sv - input word stream and decoded result stream of the unswizzle receiver
interface bit_unswizzle_rx_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_c;
  logic       out_d0;
  logic [1:0] out_err;

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_c, out_d0, out_err
  );

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_c, out_d0, out_err
  );
endinterface

// File: rtl/bit_unswizzle_rx_skid_buf.sv
// rtl/bit_unswizzle_rx_skid_buf.sv - 2-entry in-order valid/ready skid buffer for decoded swizzle words
module swz_skid_buf
  import swz_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  swz_dec_t in_data_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output swz_dec_t out_data_o
);

  occ_e     state_q, state_d;
  swz_dec_t head_q, head_d;
  swz_dec_t tail_q, tail_d;
  logic     accept, emit;

  // Ready is a pure decode of the occupancy register, so it never sees out_ready
  assign in_ready_o  = (state_q != OCC_FULL);
  assign out_valid_o = (state_q != OCC_EMPTY);
  assign out_data_o  = head_q;

  // Occupancy register plus head/tail storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next occupancy and data movement; head only changes when it is consumed or first filled
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    accept  = in_valid_i && (state_q != OCC_FULL);
    emit    = out_ready_i && (state_q != OCC_EMPTY);
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d = OCC_ONE;
          head_d  = in_data_i;
        end
      end
      OCC_ONE: begin
        if (accept && emit) begin
          head_d = in_data_i;
        end else if (accept) begin
          state_d = OCC_FULL;
          tail_d  = in_data_i;
        end else if (emit) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (emit) begin
          state_d = OCC_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

endmodule

// File: rtl/bit_unswizzle_rx.sv
// rtl/bit_unswizzle_rx.sv - swizzle word decoder with skid-buffered output and saturating error statistics
module bit_unswizzle_rx
  import swz_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter logic [2:0] CONST_PAT = SWZ_CONST
) (
  input  logic                clk,
  input  logic                reset_n,
  bit_unswizzle_rx_if.slave   bus,
  input  logic                clr_stats,
  output logic [CNT_W-1:0]    word_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                err_sticky,
  output logic [8:0]          first_err_y
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  swz_dec_t         dec, head;
  logic             in_ready_w, accept, dec_bad;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic [8:0]       first_err_y_q, first_err_y_d;

  assign dec     = swz_decode(bus.in_y, CONST_PAT);
  assign dec_bad = |dec.err;
  assign accept  = bus.in_valid && in_ready_w;

  swz_skid_buf u_skid (
    .clk         (clk),
    .rst_n       (reset_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (in_ready_w),
    .in_data_i   (dec),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (head)
  );

  assign bus.in_ready = in_ready_w;
  assign bus.out_c    = head.c;
  assign bus.out_d0   = head.d0;
  assign bus.out_err  = head.err;

  assign word_cnt    = word_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign err_sticky  = err_sticky_q;
  assign first_err_y = first_err_y_q;

  // Statistics count accepted words; a clear wins over a same-cycle accept
  always_comb begin
    word_cnt_d    = word_cnt_q;
    err_cnt_d     = err_cnt_q;
    err_sticky_d  = err_sticky_q;
    first_err_y_d = first_err_y_q;
    if (clr_stats) begin
      word_cnt_d    = '0;
      err_cnt_d     = '0;
      err_sticky_d  = 1'b0;
      first_err_y_d = '0;
    end else if (accept) begin
      if (!(&word_cnt_q)) word_cnt_d = word_cnt_q + CNT_ONE;
      if (dec_bad) begin
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_ONE;
        if (!err_sticky_q) begin
          err_sticky_d  = 1'b1;
          first_err_y_d = bus.in_y;
        end
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt_q    <= '0;
      err_cnt_q     <= '0;
      err_sticky_q  <= 1'b0;
      first_err_y_q <= '0;
    end else begin
      word_cnt_q    <= word_cnt_d;
      err_cnt_q     <= err_cnt_d;
      err_sticky_q  <= err_sticky_d;
      first_err_y_q <= first_err_y_d;
    end
  end

endmodule

// File: tb/tb_bit_unswizzle_rx.sv
// tb/tb_bit_unswizzle_rx.sv - directed vector bench for bit_unswizzle_rx
module tb_bit_unswizzle_rx;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] word_cnt, err_cnt;
  logic             err_sticky;
  logic [8:0]       first_err_y;

  int checks = 0;
  int failures = 0;

  bit_unswizzle_rx_if bus ();

  bit_unswizzle_rx #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .clr_stats   (clr_stats),
    .word_cnt    (word_cnt),
    .err_cnt     (err_cnt),
    .err_sticky  (err_sticky),
    .first_err_y (first_err_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] y;
    logic [2:0] c;
    logic       d0;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input vec_t v);
    chk({name, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, ".c"},     32'(bus.out_c),     32'(v.c));
    chk({name, ".d0"},    32'(bus.out_d0),    32'(v.d0));
    chk({name, ".err"},   32'(bus.out_err),   32'(v.err));
  endtask

  initial begin
    int  exp_wc;
    int  exp_ec;
    logic       exp_sticky;
    logic [8:0] exp_first;

    vecs[0] = '{9'b111110101, 3'b110, 1'b1, 2'b00};
    vecs[1] = '{9'b011100101, 3'b010, 1'b1, 2'b01};
    vecs[2] = '{9'b000000100, 3'b000, 1'b0, 2'b10};
    vecs[3] = '{9'b000010110, 3'b000, 1'b0, 2'b11};
    vecs[4] = '{9'b100001101, 3'b101, 1'b0, 2'b00};
    vecs[5] = '{9'b011011101, 3'b011, 1'b1, 2'b01};
    vecs[6] = '{9'b110111111, 3'b111, 1'b1, 2'b11};

    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst.out_valid",   32'(bus.out_valid), 32'd0);
    chk("rst.in_ready",    32'(bus.in_ready),  32'd1);
    chk("rst.out_c",       32'(bus.out_c),     32'd0);
    chk("rst.out_err",     32'(bus.out_err),   32'd0);
    chk("rst.word_cnt",    32'(word_cnt),      32'd0);
    chk("rst.err_sticky",  32'(err_sticky),    32'd0);
    chk("rst.first_err_y", 32'(first_err_y),   32'd0);
    reset_n = 1'b1;
    tick();

    // Table: one word per cycle, streaming with out_ready held high
    exp_wc = 0; exp_ec = 0; exp_sticky = 1'b0; exp_first = '0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_y     = vecs[i].y;
      tick();
      exp_wc++;
      if (vecs[i].err != 2'b00) begin
        exp_ec++;
        if (!exp_sticky) begin
          exp_sticky = 1'b1;
          exp_first  = vecs[i].y;
        end
      end
      chk_out($sformatf("v%0d", i), vecs[i]);
      chk($sformatf("v%0d.word_cnt", i),    32'(word_cnt),    32'(exp_wc));
      chk($sformatf("v%0d.err_cnt", i),     32'(err_cnt),     32'(exp_ec));
      chk($sformatf("v%0d.err_sticky", i),  32'(err_sticky),  32'(exp_sticky));
      chk($sformatf("v%0d.first_err_y", i), 32'(first_err_y), 32'(exp_first));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: words A, B, C with the sink stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_y      = vecs[4].y;
    tick();
    chk_out("bp.A1", vecs[4]);
    chk("bp.ready_one", 32'(bus.in_ready), 32'd1);
    bus.in_y = vecs[0].y;
    tick();
    chk("bp.ready_full", 32'(bus.in_ready), 32'd0);
    chk_out("bp.A2", vecs[4]);
    bus.in_y = vecs[5].y;
    tick();
    chk("bp.ready_hold", 32'(bus.in_ready), 32'd0);
    chk_out("bp.A3", vecs[4]);
    bus.out_ready = 1'b1;
    tick();
    chk_out("bp.B", vecs[0]);
    chk("bp.ready_after", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_out("bp.C", vecs[5]);
    tick();
    chk("bp.empty", 32'(bus.out_valid), 32'd0);
    chk("bp.word_cnt", 32'(word_cnt), 32'(exp_wc + 3));

    // Saturation then clear racing an accept
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr.word_cnt", 32'(word_cnt), 32'd0);
    chk("clr.err_sticky", 32'(err_sticky), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_y     = vecs[0].y;
    for (int i = 0; i < 20; i++) tick();
    chk("sat.word_cnt", 32'(word_cnt), 32'd15);
    chk("sat.err_cnt",  32'(err_cnt),  32'd0);
    bus.in_y  = vecs[3].y;
    clr_stats = 1'b1;
    tick();
    clr_stats    = 1'b0;
    bus.in_valid = 1'b0;
    chk("clracc.word_cnt",    32'(word_cnt),    32'd0);
    chk("clracc.err_cnt",     32'(err_cnt),     32'd0);
    chk("clracc.err_sticky",  32'(err_sticky),  32'd0);
    chk("clracc.first_err_y", 32'(first_err_y), 32'd0);
    chk_out("clracc.word", vecs[3]);
    tick();

    // Asynchronous reset while FULL and stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_y      = vecs[1].y;
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("ar.full", 32'(bus.in_ready), 32'd0);
    chk("ar.word_cnt_pre", 32'(word_cnt), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar.in_ready",  32'(bus.in_ready),  32'd1);
    chk("ar.word_cnt",  32'(word_cnt),      32'd0);
    chk("ar.err_cnt",   32'(err_cnt),       32'd0);
    chk("ar.err_sticky", 32'(err_sticky),   32'd0);
    #3;
    reset_n = 1'b1;
    tick();
    chk("ar.after_valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_unswizzle_rx.md
Name: bit_unswizzle_rx

Overview:
- Receive-side counterpart of the 9-bit swizzle word: Y = {C[2:1], {3{D[0]}}, C[0], 3'b101}.
- Accepts swizzled words on a valid/ready stream, recovers C[2:0] and D[0], and checks the constant field and the replication field.
- Forwards decoded results through a 2-entry skid buffer and keeps saturating word and error statistics.
- Sits downstream of the swizzle generator in the bit-manipulation datapath examples.

Parameters:
- CNT_W, 16, width of the word and error statistic counters.
- CONST_PAT, 3'b101, expected value of Y[2:0].

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_y  in  9  swizzled word.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts the result.
- out_c  out  3  recovered {Y[8:7], Y[3]}.
- out_d0  out  1  majority vote of Y[6:4].
- out_err  out  2  bit1 = constant mismatch, bit0 = replication mismatch.
- clr_stats  in  1  synchronous clear of the statistics.
- word_cnt  out  CNT_W  accepted words, saturating.
- err_cnt  out  CNT_W  accepted words with out_err != 0, saturating.
- err_sticky  out  1  set on the first erroneous word.
- first_err_y  out  9  raw in_y of the first erroneous word.

Behaviour:
- Reset is asynchronous, active-low: while reset_n = 0, clk is ignored.
- Reset values:
  - FIFO occupancy = 0, so out_valid = 0 and in_ready = 1.
  - out_c, out_d0, out_err = 0.
  - Counters = 0, err_sticky = 0, first_err_y = 0.
- Reset mid-transfer discards all buffered words.
- Decode (combinational on in_y, registered into the buffer):
  - c = {Y[8:7], Y[3]}.
  - d0 = majority(Y[6:4]).
  - rep_err = (Y[6:4] != 3'b000 && Y[6:4] != 3'b111).
  - const_err = (Y[2:0] != CONST_PAT).
- Handshakes:
  - Accept happens when in_valid && in_ready at a rising edge.
  - Emit happens when out_valid && out_ready.
- Latency: 1 cycle. A word accepted at edge N is visible on the outputs after edge N when the buffer was empty.
- Buffer: 2-entry skid buffer, in-order.
  - Occupancy states: EMPTY (0), ONE (1), FULL (2).
  - in_ready = (occupancy != FULL) and is registered; it never depends combinationally on out_ready.
  - out_valid = (occupancy != EMPTY).
  - Transitions:
    - EMPTY + accept → ONE.
    - ONE + accept, no emit → FULL.
    - ONE + emit, no accept → EMPTY.
    - ONE + accept + emit → ONE (new word becomes head).
    - FULL + emit → ONE.
    - FULL: no accept possible.
- Output fields must hold stable while out_valid && !out_ready.
- Statistics update on accept, not on emit:
  - word_cnt += 1, saturating at 2^CNT_W − 1.
  - If the word has an error: err_cnt += 1 (saturating).
  - If an erroneous word is accepted while err_sticky = 0: capture first_err_y = in_y and set err_sticky.
- clr_stats:
  - Zeroes word_cnt, err_cnt, err_sticky, first_err_y.
  - Has priority over a same-cycle accept; that accepted word is not counted.
  - Does not affect the data buffer.
- Any in_y bit that is X or Z counts as a mismatch in simulation checks only; RTL needs no special handling.

Decomposition:
- Package swz_pkg holds:
  - localparams for field positions: C_HI = 8:7, REP = 6:4, C_LO = 3, CONST = 2:0.
  - SWZ_CONST = 3'b101.
  - typedef struct packed { logic [2:0] c; logic d0; logic [1:0] err; } swz_dec_t.
  - function swz_decode(logic [8:0]) returning swz_dec_t.
- One sub-module, swz_skid_buf: generic 2-entry valid/ready skid buffer carrying swz_dec_t.
- The top level holds the decode logic and the statistics.

Test Plan:
- Clean word: reset; in_y = 9'b111110101 (C = 5'b10110, D = 5'b00001) with out_ready = 1 → one cycle later out_valid = 1, out_c = 3'b110, out_d0 = 1, out_err = 2'b00; word_cnt = 1, err_cnt = 0.
- Replication error: in_y = 9'b011100101 → out_c = 3'b010, out_d0 = 1, out_err = 2'b01; err_sticky = 1, first_err_y = 9'b011100101.
- Constant error: in_y = 9'b000000100 → out_err = 2'b10; a following word with both errors, 9'b000010110, leaves first_err_y unchanged and err_cnt = 2.
- Backpressure: out_ready = 0 while sending 3 words back-to-back → in_ready falls after the 2nd accept, and out_* hold word 1. Raising out_ready drains the words in order 1, 2, 3 with no loss and no duplicate.
- Saturation and clear: CNT_W = 4; send 20 clean words → word_cnt sticks at 15. Assert clr_stats in the same cycle as an accept → all statistics = 0 the next cycle and the accepted word still emerges on the output.
- Reset mid-operation: FULL with out_ready = 0, pulse reset_n low asynchronously (between clock edges) → out_valid = 0 and in_ready = 1 immediately, counters = 0.
